sd_sector_uart_reader: RTL and testbench
========================================

Name: sd_sector_uart_reader

Overview:
Read-back counterpart of the UART-to-SD write path. On a start pulse it requests N consecutive 512-byte sectors from the SD read engine, starting at a given sector address. Each sector's 256 16-bit words are buffered in an internal RAM. The buffered words are then serialised as bytes (high byte first) to the UART transmitter, which has no busy output, using a fixed inter-byte gap. It sits between the SD read controller (rd_en/rd_addr/rd_busy/rd_data_en/rd_data) and the UART TX (pi_data/pi_flag).

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
UART_BPS, 9600, UART baud rate
BYTE_GAP, (CLK_FREQ/UART_BPS)*10, clocks between successive tx_flag pulses (52080 at defaults); overridable for simulation
WORDS_PER_SECTOR, 256, 16-bit words per sector; buffer depth

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
start_addr  in  32  first sector address, latched on start
sector_cnt  in  16  sectors to read, latched on start
rd_busy  in  1  SD read engine busy
rd_data_en  in  1  one-cycle strobe, rd_data valid
rd_data  in  16  sector word from SD
rd_en  out  1  one-cycle read request pulse
rd_addr  out  32  sector address; held stable from the rd_en pulse until rd_busy falls
tx_data  out  8  byte to UART TX
tx_flag  out  1  one-cycle byte-valid pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of job
err  out  1  sticky word-count error; cleared on accepted start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and latched registers 0. Reset mid-job aborts the job immediately; nothing resumes after reset release.
- States: IDLE, REQ, WAIT_ACK, FILL, DRAIN, GAP, NEXT.
- IDLE: on start, latch start_addr/sector_cnt and clear err.
  - sector_cnt==0: pulse done on the next cycle, stay in IDLE, no rd_en.
  - Otherwise go to REQ.
  - start while busy is ignored.
- REQ: rd_addr<=cur_addr, rd_en=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: wait for rd_busy=1. No timeout. A rd_data_en arriving here is still captured.
- FILL: on each rd_data_en, write rd_data to buf[wcnt] and increment wcnt.
  - Writes beyond WORDS_PER_SECTOR are dropped and set err.
  - On rd_busy 1->0, go to DRAIN. If wcnt != WORDS_PER_SECTOR at that point, set err.
  - Only the words actually received are drained (wcnt may be less than 256).
- DRAIN: for word i, emit buf[i][15:8] then buf[i][7:0].
  - First tx_flag occurs 2 cycles after entering DRAIN (RAM read latency 1).
  - Each subsequent tx_flag occurs exactly BYTE_GAP cycles after the previous one.
  - tx_data is valid in the tx_flag cycle and held until the next byte.
  - 2*wcnt bytes per sector. wcnt==0 skips straight to GAP.
- GAP: wait BYTE_GAP cycles after the last tx_flag so the UART frame completes, then NEXT.
- NEXT: cur_addr += 1 (32-bit, wraps FFFFFFFF->0); remaining -= 1.
  - remaining==0: done=1 for one cycle, go to IDLE.
  - Otherwise go to REQ.
- Inputs rd_data_en/rd_busy outside WAIT_ACK/FILL are ignored.
- The gap counter width is ceil(log2(BYTE_GAP+1)). It never produces a tx_flag spacing below BYTE_GAP.

Test Plan:
1. BYTE_GAP=20, start_addr=0x100, sector_cnt=1, SD model returns words 0x0000..0x00FF:
   - exactly one rd_en, with rd_addr=0x100;
   - 512 tx_flag pulses spaced 20 cycles apart, bytes 00,00,00,01,...,00,FF;
   - done pulses once, err=0.
2. sector_cnt=3, start_addr=0xFFFFFFFE:
   - rd_addr sequence FFFFFFFE, FFFFFFFF, 00000000;
   - 1536 bytes sent, single done pulse.
3. SD model delivers only 200 words, then drops rd_busy: 400 bytes sent, err=1, done pulses. The next start clears err.
4. SD model delivers 260 words: first 256 buffered and sent (512 bytes), err=1.
5. start asserted during DRAIN, and sector_cnt=0 from IDLE:
   - start during DRAIN is ignored (still one job);
   - sector_cnt=0 gives done one cycle later with no rd_en and no tx_flag.
6. sys_rst_n low mid-DRAIN: all outputs 0 and busy=0 immediately. After release, no tx_flag until a new start.

Source files
------------

// File: rtl/sd_sector_uart_reader_if.sv
// SD read-engine bus between the sector reader (master) and the SD read controller (slave).
interface sd_sector_uart_reader_if;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        rd_busy;
    logic        rd_data_en;
    logic [15:0] rd_data;

    modport master (output rd_en, rd_addr, input rd_busy, rd_data_en, rd_data);
    modport slave  (input rd_en, rd_addr, output rd_busy, rd_data_en, rd_data);
endinterface

// File: rtl/sd_sector_uart_reader.sv
// Reads N SD sectors into a one-sector buffer and streams each buffer to a
// busy-less UART TX, high byte first, one byte every BYTE_GAP clocks.
module sd_sector_uart_reader #(
    parameter int unsigned CLK_FREQ         = 50_000_000,
    parameter int unsigned UART_BPS         = 9600,
    parameter int unsigned BYTE_GAP         = (CLK_FREQ / UART_BPS) * 10,
    parameter int unsigned WORDS_PER_SECTOR = 256
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           start,
    input  logic [31:0]                    start_addr,
    input  logic [15:0]                    sector_cnt,
    sd_sector_uart_reader_if.master        sd,
    output logic [7:0]                     tx_data,
    output logic                           tx_flag,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned AW  = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
    localparam int unsigned WCW = $clog2(WORDS_PER_SECTOR + 1);
    localparam int unsigned BCW = WCW + 1;
    localparam int unsigned GW  = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_ACK, S_FILL, S_DRAIN, S_GAP, S_NEXT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [15:0]     remaining_q, remaining_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            rd_en_q, rd_en_d;
    logic [31:0]     rd_addr_q, rd_addr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_flag_q, tx_flag_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [15:0]     mem [WORDS_PER_SECTOR];
    logic [15:0]     rdata_q;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [AW-1:0]   mem_raddr;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        wcnt_d      = wcnt_q;
        bcnt_d      = bcnt_q;
        gcnt_d      = gcnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        tx_data_d   = tx_data_q;
        tx_flag_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = AW'(wcnt_q);

        // Word capture is live from the request ack onward; overflow words are dropped.
        if ((state_q == S_WAIT_ACK || state_q == S_FILL) && sd.rd_data_en) begin
            if (wcnt_q < WCW'(WORDS_PER_SECTOR)) begin
                mem_we = 1'b1;
                wcnt_d = WCW'(wcnt_q + 1'b1);
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    remaining_d = sector_cnt;
                    err_d       = 1'b0;
                    if (sector_cnt == 16'd0) done_d  = 1'b1;
                    else                     state_d = S_REQ;
                end
            end
            S_REQ: begin
                rd_en_d   = 1'b1;
                rd_addr_d = cur_addr_q;
                wcnt_d    = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (sd.rd_busy) state_d = S_FILL;
            end
            S_FILL: begin
                if (!sd.rd_busy) begin
                    if (wcnt_d != WCW'(WORDS_PER_SECTOR)) err_d = 1'b1;
                    bcnt_d = '0;
                    // One priming cycle lets the RAM deliver word 0 before the first byte.
                    if (wcnt_d == '0) begin
                        gcnt_d  = '0;
                        state_d = S_GAP;
                    end else begin
                        gcnt_d  = GW'(1);
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (gcnt_q != '0) begin
                    gcnt_d = GW'(gcnt_q - 1'b1);
                end else begin
                    tx_flag_d = 1'b1;
                    tx_data_d = bcnt_q[0] ? rdata_q[7:0] : rdata_q[15:8];
                    bcnt_d    = BCW'(bcnt_q + 1'b1);
                    gcnt_d    = GW'(BYTE_GAP - 1);
                    if (BCW'(bcnt_q + 1'b1) == {wcnt_q, 1'b0}) state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q != '0) gcnt_d  = GW'(gcnt_q - 1'b1);
                else              state_d = S_NEXT;
            end
            S_NEXT: begin
                cur_addr_d  = cur_addr_q + 32'd1;
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        mem_raddr = AW'(bcnt_d >> 1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            gcnt_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            tx_data_q   <= '0;
            tx_flag_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            wcnt_q      <= wcnt_d;
            bcnt_q      <= bcnt_d;
            gcnt_q      <= gcnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            tx_data_q   <= tx_data_d;
            tx_flag_q   <= tx_flag_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Sector buffer: synchronous write, registered read.
    always_ff @(posedge sys_clk) begin
        if (mem_we) mem[mem_waddr] <= sd.rd_data;
        rdata_q <= mem[mem_raddr];
    end

    assign sd.rd_en   = rd_en_q;
    assign sd.rd_addr = rd_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_flag    = tx_flag_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sd_sector_uart_reader.sv
// Directed bench for sd_sector_uart_reader with a behavioural SD read engine.
module tb_sd_sector_uart_reader;

    localparam int GAP = 20;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        start      = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] sector_cnt = '0;
    logic [7:0]  tx_data;
    logic        tx_flag, busy, done, err;

    sd_sector_uart_reader_if bus ();

    sd_sector_uart_reader #(.BYTE_GAP(GAP)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .start_addr (start_addr),
        .sector_cnt (sector_cnt),
        .sd         (bus.master),
        .tx_data    (tx_data),
        .tx_flag    (tx_flag),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output log, sampled on the falling edge.
    logic [7:0]  txq[$];
    int          txc[$];
    logic [31:0] addrq[$];
    int          done_cnt = 0;

    always @(negedge sys_clk) begin
        if (tx_flag) begin
            txq.push_back(tx_data);
            txc.push_back(cyc);
        end
        if (bus.rd_en) addrq.push_back(bus.rd_addr);
        if (done) done_cnt++;
    end

    function automatic logic [15:0] exp_word(input logic [31:0] a, input int k);
        return 16'(k) ^ {a[7:0], 8'h00};
    endfunction

    // SD read engine model: ack, stream n_words, then drop busy.
    int n_words       = 256;
    int fall_cyc      = 0;
    int addr_unstable = 0;

    initial begin
        logic [31:0] a;
        bus.rd_busy    = 1'b0;
        bus.rd_data_en = 1'b0;
        bus.rd_data    = '0;
        forever begin
            @(negedge sys_clk);
            if (bus.rd_en) begin
                a = bus.rd_addr;
                repeat (3) @(negedge sys_clk);
                bus.rd_busy = 1'b1;
                for (int k = 0; k < n_words; k++) begin
                    @(negedge sys_clk);
                    bus.rd_data_en = 1'b1;
                    bus.rd_data    = exp_word(a, k);
                    @(negedge sys_clk);
                    bus.rd_data_en = 1'b0;
                    if (bus.rd_addr !== a) addr_unstable++;
                end
                @(negedge sys_clk);
                bus.rd_busy = 1'b0;
                fall_cyc    = cyc;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] n);
        start_addr = a;
        sector_cnt = n;
        start      = 1'b1;
        @(negedge sys_clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c0 = done_cnt;
        int n  = 0;
        while (done_cnt == c0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != c0), 64'd1);
    endtask

    task automatic wait_tx(input string tag, input int base, input int k, input int budget);
        int n = 0;
        while (txq.size() - base < k && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_tx_seen"}, 64'(txq.size() - base >= k), 64'd1);
    endtask

    task automatic check_stream(input string tag, input int j0, input logic [31:0] base,
                                input int nsec, input int nw);
        int nbad = 0;
        int j    = j0;
        logic [15:0] w;
        for (int s = 0; s < nsec; s++) begin
            for (int k = 0; k < nw; k++) begin
                w = exp_word(base + 32'(s), k);
                if (j >= txq.size() || txq[j] !== w[15:8]) nbad++;
                j++;
                if (j >= txq.size() || txq[j] !== w[7:0]) nbad++;
                j++;
            end
        end
        chk({tag, "_bytes"}, 64'(nbad), 64'd0);
    endtask

    task automatic count_gaps(input int i0, output int n_eq, output int n_lt);
        n_eq = 0;
        n_lt = 0;
        for (int i = i0 + 1; i < txc.size(); i++) begin
            if (txc[i] - txc[i-1] == GAP)     n_eq++;
            else if (txc[i] - txc[i-1] < GAP) n_lt++;
        end
    endtask

    initial begin
        int tx0, a0, d0, n_eq, n_lt;

        // Reset values
        repeat (2) @(negedge sys_clk);
        chk("reset_ctl", 64'({bus.rd_en, tx_flag, busy, done, err}), 64'd0);
        chk("reset_bus", 64'({bus.rd_addr, tx_data}), 64'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 1: one sector at 0x100, stray start during DRAIN
        tx0 = txq.size(); a0 = addrq.size(); d0 = done_cnt; n_words = 256;
        do_start(32'h100, 16'd1);
        @(negedge sys_clk);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_tx("t1", tx0, 5, 2000);
        do_start(32'h500, 16'd5);
        wait_done("t1", 15000);
        repeat (5) @(negedge sys_clk);
        chk("t1_rd_en_cnt", 64'(addrq.size() - a0), 64'd1);
        chk("t1_rd_addr", 64'(addrq[a0]), 64'h100);
        chk("t1_tx_cnt", 64'(txq.size() - tx0), 64'd512);
        check_stream("t1", tx0, 32'h100, 1, 256);
        count_gaps(tx0, n_eq, n_lt);
        chk("t1_gap_eq", 64'(n_eq), 64'd511);
        chk("t1_first_lat", 64'(txc[tx0] - fall_cyc), 64'd3);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_addr_stable", 64'(addr_unstable), 64'd0);

        // 2: three sectors across the 32-bit address wrap
        tx0 = txq.size(); a0 = addrq.size(); d0 = done_cnt;
        do_start(32'hFFFF_FFFE, 16'd3);
        wait_done("t2", 40000);
        repeat (5) @(negedge sys_clk);
        chk("t2_rd_en_cnt", 64'(addrq.size() - a0), 64'd3);
        chk("t2_addr0", 64'(addrq[a0]),     64'hFFFF_FFFE);
        chk("t2_addr1", 64'(addrq[a0 + 1]), 64'hFFFF_FFFF);
        chk("t2_addr2", 64'(addrq[a0 + 2]), 64'h0000_0000);
        chk("t2_tx_cnt", 64'(txq.size() - tx0), 64'd1536);
        check_stream("t2", tx0, 32'hFFFF_FFFE, 3, 256);
        count_gaps(tx0, n_eq, n_lt);
        chk("t2_gap_eq", 64'(n_eq), 64'd1533);
        chk("t2_gap_lt", 64'(n_lt), 64'd0);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_err", 64'(err), 64'd0);

        // 3: short sector of 200 words
        tx0 = txq.size(); d0 = done_cnt; n_words = 200;
        do_start(32'h20, 16'd1);
        wait_done("t3", 12000);
        repeat (5) @(negedge sys_clk);
        chk("t3_tx_cnt", 64'(txq.size() - tx0), 64'd400);
        check_stream("t3", tx0, 32'h20, 1, 200);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 4: long sector of 260 words; start clears err
        tx0 = txq.size(); d0 = done_cnt; n_words = 260;
        do_start(32'h30, 16'd1);
        chk("t4_err_clr", 64'(err), 64'd0);
        wait_done("t4", 15000);
        repeat (5) @(negedge sys_clk);
        chk("t4_tx_cnt", 64'(txq.size() - tx0), 64'd512);
        check_stream("t4", tx0, 32'h30, 1, 256);
        chk("t4_err", 64'(err), 64'd1);

        // 5: zero-sector job
        tx0 = txq.size(); a0 = addrq.size(); d0 = done_cnt; n_words = 256;
        do_start(32'h40, 16'd0);
        chk("t5_done", 64'({done, busy}), 64'b10);
        chk("t5_err_clr", 64'(err), 64'd0);
        @(negedge sys_clk);
        chk("t5_done_low", 64'(done), 64'd0);
        repeat (30) @(negedge sys_clk);
        chk("t5_no_rd_en", 64'(addrq.size() - a0), 64'd0);
        chk("t5_no_tx", 64'(txq.size() - tx0), 64'd0);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 6: reset in the middle of DRAIN
        tx0 = txq.size();
        do_start(32'h50, 16'd2);
        wait_tx("t6", tx0, 10, 3000);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 64'({bus.rd_en, tx_flag, busy, done, err}), 64'd0);
        chk("t6_rst_bus", 64'({bus.rd_addr, tx_data}), 64'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tx0 = txq.size(); a0 = addrq.size();
        repeat (200) @(negedge sys_clk);
        chk("t6_no_tx", 64'(txq.size() - tx0), 64'd0);
        chk("t6_no_rd_en", 64'(addrq.size() - a0), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
